tdc_sample_averager: RTL and testbench

TDC_SAMPLE_AVERAGER -- requirements
Module: tdc_sample_averager

---
 rtl/tdc_pkg.sv | 13 +
 rtl/tdc_sample_averager_if.sv | 28 ++
 rtl/tdc_minmax_tracker.sv | 35 +++
 rtl/tdc_sample_averager.sv | 98 +++++++++
 tb/tb_tdc_sample_averager.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// Shared constants and FSM state type for the TDC sample averager.
package tdc_pkg;

    localparam int unsigned TDC_DATA_W = 8;
    localparam int unsigned TDC_LOG2_N = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } tdc_state_e;

endpackage

// File: rtl/tdc_sample_averager_if.sv
// Sample/result bus of the TDC sample averager.
// master: the side feeding samples and consuming results; slave: the averager.
interface tdc_sample_averager_if
    import tdc_pkg::*;
#(
    parameter int unsigned DATA_W = TDC_DATA_W
);
    logic              start;
    logic              s_valid;
    logic [DATA_W-1:0] s_code;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_mean;
    logic [DATA_W-1:0] m_min;
    logic [DATA_W-1:0] m_max;
    logic              busy;
    logic              dropped;

    modport master (
        output start, s_valid, s_code, m_ready,
        input  m_valid, m_mean, m_min, m_max, busy, dropped
    );

    modport slave (
        input  start, s_valid, s_code, m_ready,
        output m_valid, m_mean, m_min, m_max, busy, dropped
    );
endinterface

// File: rtl/tdc_minmax_tracker.sv
// Running min/max of the codes in one window; first sample seeds both,
// ties leave the stored value unchanged.
module tdc_minmax_tracker
    import tdc_pkg::*;
#(
    parameter int unsigned DATA_W = TDC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] code,
    output logic [DATA_W-1:0] min,
    output logic [DATA_W-1:0] max
);
    logic seen;

    // Clear on reset or window open, otherwise fold each enabled sample in.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            min  <= '0;
            max  <= '0;
            seen <= 1'b0;
        end else if (en) begin
            if (!seen) begin
                min  <= code;
                max  <= code;
                seen <= 1'b1;
            end else begin
                if (code < min) min <= code;
                if (code > max) max <= code;
            end
        end
    end
endmodule

// File: rtl/tdc_sample_averager.sv
// Averages 2**LOG2_N TDC codes per window and holds the result until taken.
// Optional min/max tracking is built only when TDC_AVG_MINMAX_EN is defined.
module tdc_sample_averager
    import tdc_pkg::*;
#(
    parameter int unsigned DATA_W = TDC_DATA_W,
    parameter int unsigned LOG2_N = TDC_LOG2_N
) (
    input logic                  clk,
    input logic                  rst,
    tdc_sample_averager_if.slave bus
);
    localparam int unsigned SUM_W = DATA_W + LOG2_N;

    tdc_state_e        state;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    logic [LOG2_N-1:0] count;
    logic              m_valid_r;
    logic [DATA_W-1:0] m_mean_r;
    logic              dropped_r;
    logic              win_clr;
    logic              win_take;

    // Next accumulator value including the sample on the bus this cycle.
    always_comb begin
        sum_next = sum + SUM_W'(bus.s_code);
        win_clr  = (state == IDLE) && bus.start;
        win_take = (state == ACCUM) && bus.s_valid;
    end

    // Window FSM: accumulate N samples, register the mean, hold until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sum       <= '0;
            count     <= '0;
            m_valid_r <= 1'b0;
            m_mean_r  <= '0;
            dropped_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= ACCUM;
                        sum       <= '0;
                        count     <= '0;
                        dropped_r <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (bus.s_valid) begin
                        if (&count) begin
                            m_mean_r  <= DATA_W'(sum_next >> LOG2_N);
                            m_valid_r <= 1'b1;
                            sum       <= '0;
                            count     <= '0;
                            state     <= HOLD;
                        end else begin
                            sum   <= sum_next;
                            count <= count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.s_valid) dropped_r <= 1'b1;
                    if (bus.m_ready) begin
                        m_valid_r <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TDC_AVG_MINMAX_EN
    tdc_minmax_tracker #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk  (clk),
        .rst  (rst),
        .clr  (win_clr),
        .en   (win_take),
        .code (bus.s_code),
        .min  (bus.m_min),
        .max  (bus.m_max)
    );
`else
    assign bus.m_min = '0;
    assign bus.m_max = '0;
`endif

    assign bus.m_valid = m_valid_r;
    assign bus.m_mean  = m_mean_r;
    assign bus.busy    = (state == ACCUM);
    assign bus.dropped = dropped_r;
endmodule

// File: tb/tb_tdc_sample_averager.sv
// Self-checking bench for tdc_sample_averager: directed windows plus a
// randomized run, compared against a queue-based window model.
module tb_tdc_sample_averager;
    import tdc_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned LN = 4;
    localparam int unsigned N  = 1 << LN;

    logic clk;
    logic rst;

    tdc_sample_averager_if #(.DATA_W(DW)) bus ();

    tdc_sample_averager #(
        .DATA_W (DW),
        .LOG2_N (LN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_errors;

    // Reference model: window contents as a queue, result computed arithmetically.
    bit          mdl_open;
    bit          mdl_pend;
    int unsigned mdl_win[$];
    int unsigned mdl_mean;
    int unsigned mdl_min;
    int unsigned mdl_max;
    bit          mdl_dropped;

`ifdef TDC_AVG_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_cycle(input bit r, input bit s, input bit v, input int unsigned c, input bit rd);
        int unsigned total;
        int unsigned lo;
        int unsigned hi;
        if (r) begin
            mdl_open = 0; mdl_pend = 0; mdl_win.delete();
            mdl_mean = 0; mdl_min = 0; mdl_max = 0; mdl_dropped = 0;
        end else if (mdl_pend) begin
            if (v)  mdl_dropped = 1;
            if (rd) mdl_pend = 0;
        end else if (mdl_open) begin
            if (v) begin
                mdl_win.push_back(c);
                total = 0; lo = mdl_win[0]; hi = mdl_win[0];
                foreach (mdl_win[i]) begin
                    total += mdl_win[i];
                    if (mdl_win[i] < lo) lo = mdl_win[i];
                    if (mdl_win[i] > hi) hi = mdl_win[i];
                end
                if (MINMAX) begin
                    mdl_min = lo;
                    mdl_max = hi;
                end
                if (mdl_win.size() == N) begin
                    mdl_mean = total / N;
                    mdl_pend = 1;
                    mdl_open = 0;
                end
            end
        end else if (s) begin
            mdl_open = 1; mdl_win.delete();
            mdl_dropped = 0; mdl_min = 0; mdl_max = 0;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit v, input logic [DW-1:0] c, input bit rd);
        rst         = r;
        bus.start   = s;
        bus.s_valid = v;
        bus.s_code  = c;
        bus.m_ready = rd;
        @(posedge clk);
        #1;
        model_cycle(r, s, v, int'(c), rd);
        check_eq("m_valid", bus.m_valid, mdl_pend);
        check_eq("busy",    bus.busy,    mdl_open);
        check_eq("dropped", bus.dropped, mdl_dropped);
        check_eq("m_mean",  bus.m_mean,  mdl_mean);
        check_eq("m_min",   bus.m_min,   mdl_min);
        check_eq("m_max",   bus.m_max,   mdl_max);
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0);
    endtask

    task automatic fill(input logic [DW-1:0] c);
        step(0, 1, 0, '0, 0);
        for (int i = 0; i < int'(N); i++) step(0, 0, 1, c, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mdl_open = 0; mdl_pend = 0; mdl_mean = 0; mdl_min = 0; mdl_max = 0; mdl_dropped = 0;

        // reset state
        step(1, 1, 1, 8'h55, 1);
        step(1, 0, 0, '0, 0);
        check_eq("rst_valid", bus.m_valid, 0);
        check_eq("rst_busy",  bus.busy, 0);
        check_eq("rst_mean",  bus.m_mean, 0);

        // s_valid in IDLE ignored
        step(0, 0, 1, 8'h77, 0);
        check_eq("idle_sv_drop", bus.dropped, 0);

        // 16 x 0x40
        fill(8'h40);
        check_eq("w40_valid", bus.m_valid, 1);
        check_eq("w40_mean",  bus.m_mean, 8'h40);
        check_eq("w40_min",   bus.m_min, MINMAX ? 8'h40 : 0);
        check_eq("w40_max",   bus.m_max, MINMAX ? 8'h40 : 0);
        step(0, 0, 0, '0, 1);

        // codes 0..15 with gaps; start-cycle sample must be ignored
        step(0, 1, 1, 8'hF0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 8'(i), 0);
            if (i % 3 == 1) idle();
        end
        check_eq("ramp_mean", bus.m_mean, 8'h07);
        check_eq("ramp_min",  bus.m_min, 0);
        check_eq("ramp_max",  bus.m_max, MINMAX ? 8'h0F : 0);
        // m_ready while valid=0 has no effect
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        check_eq("rdy_idle_valid", bus.m_valid, 0);

        // all 0xFF, no wrap
        fill(8'hFF);
        check_eq("wff_mean", bus.m_mean, 8'hFF);

        // pending result, 5 cycles without ready and 3 sample pulses
        for (int k = 0; k < 5; k++) step(0, 1, (k < 3), 8'hAA, 0);
        check_eq("hold_mean",    bus.m_mean, 8'hFF);
        check_eq("hold_valid",   bus.m_valid, 1);
        check_eq("hold_dropped", bus.dropped, 1);
        step(0, 0, 0, '0, 1);
        step(0, 1, 0, '0, 0);
        check_eq("restart_dropped", bus.dropped, 0);
        idle();
        step(1, 0, 0, '0, 0);

        // reset mid-window
        step(0, 1, 0, '0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 8'h33, 0);
        step(1, 0, 1, 8'h33, 0);
        check_eq("midrst_busy",  bus.busy, 0);
        check_eq("midrst_valid", bus.m_valid, 0);
        fill(8'h20);
        check_eq("w20_mean", bus.m_mean, 8'h20);
        step(0, 0, 0, '0, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) != 0),
                 8'($urandom),
                 ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
